// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the MDU occupancy state type; values only, no logic.
package pipeline_pkg;

    localparam int             REG_AW              = 5;
    localparam logic [4:0]     REG_ZERO            = 5'd0;
    localparam int             DEFAULT_MDU_LATENCY = 4;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_busy_tracker.sv
// Counts down the cycles an in-flight mult/div still occupies the MDU after leaving EX.
module mdu_busy_tracker
    import pipeline_pkg::*;
#(
    parameter int MDU_LATENCY = DEFAULT_MDU_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mdu_startE,
    output logic mdu_busy
);

    localparam int CW = $clog2(MDU_LATENCY + 1);

    logic [CW-1:0] cnt;
    mdu_state_t    mduState;

    // A new start always reloads, even over an operation still counting down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (mdu_startE) begin
            cnt <= CW'(MDU_LATENCY);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign mduState = (cnt != '0) ? MDU_BUSY : MDU_IDLE;
    assign mdu_busy = (mduState == MDU_BUSY);

endmodule

// File: rtl/stall_flush_ctrl.sv
// Stall/flush generator for the 5-stage pipeline (load-use, D-stage branch, MDU busy).
// Optional perf counters stall_cycles/flush_count are enabled by defining STALL_PERF_EN.
module stall_flush_ctrl
    import pipeline_pkg::*;
#(
    parameter int MDU_LATENCY = DEFAULT_MDU_LATENCY,
    parameter int REG_AW      = pipeline_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_addrD,
    input  logic [REG_AW-1:0] rt_addrD,
    input  logic              uses_rsD,
    input  logic              uses_rtD,
    input  logic              branchD,
    input  logic              branch_takenD,
    input  logic              reg_writeE,
    input  logic              mem_to_regE,
    input  logic [REG_AW-1:0] write_reg_addrE,
    input  logic              mem_to_regM,
    input  logic [REG_AW-1:0] write_reg_addrM,
    input  logic              mdu_startE,
    input  logic              mdu_useD,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushE,
    output logic              mdu_busy
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_count
`endif
);

    logic matchE;
    logic matchM;
    logic lwStall;
    logic brStall;
    logic mduStall;
    logic stall;
    logic flush;

    mdu_busy_tracker #(
        .MDU_LATENCY (MDU_LATENCY)
    ) uMduBusyTracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .mdu_startE (mdu_startE),
        .mdu_busy   (mdu_busy)
    );

    // Writes to $0 are discarded by the register file, so they never create a dependency.
    always_comb begin
        matchE = ((uses_rsD && rs_addrD == write_reg_addrE) ||
                  (uses_rtD && rt_addrD == write_reg_addrE)) &&
                 (write_reg_addrE != REG_AW'(REG_ZERO));
        matchM = ((uses_rsD && rs_addrD == write_reg_addrM) ||
                  (uses_rtD && rt_addrD == write_reg_addrM)) &&
                 (write_reg_addrM != REG_AW'(REG_ZERO));
    end

    // Reset masks every output so the pipeline comes up free-running with no bubbles.
    always_comb begin
        lwStall  = mem_to_regE && matchE;
        brStall  = branchD && ((reg_writeE && matchE) || (mem_to_regM && matchM));
        mduStall = mdu_useD && mdu_busy;
        stall    = rst_n && (lwStall || brStall || mduStall);
        flush    = rst_n && branch_takenD && !stall;
    end

    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;
    assign flushD = flush;

`ifdef STALL_PERF_EN
    // Free-running event counters; both wrap naturally at their width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed self-checking bench for stall_flush_ctrl with hand-computed expectations.
module tb_stall_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_addrD = '0;
    logic [4:0] rt_addrD = '0;
    logic       uses_rsD = 1'b0;
    logic       uses_rtD = 1'b0;
    logic       branchD = 1'b0;
    logic       branch_takenD = 1'b0;
    logic       reg_writeE = 1'b0;
    logic       mem_to_regE = 1'b0;
    logic [4:0] write_reg_addrE = '0;
    logic       mem_to_regM = 1'b0;
    logic [4:0] write_reg_addrM = '0;
    logic       mdu_startE = 1'b0;
    logic       mdu_useD = 1'b0;
    logic       stallF;
    logic       stallD;
    logic       flushD;
    logic       flushE;
    logic       mdu_busy;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int checkCount = 0;
    int failCount  = 0;

    stall_flush_ctrl #(
        .MDU_LATENCY (4),
        .REG_AW      (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs_addrD        (rs_addrD),
        .rt_addrD        (rt_addrD),
        .uses_rsD        (uses_rsD),
        .uses_rtD        (uses_rtD),
        .branchD         (branchD),
        .branch_takenD   (branch_takenD),
        .reg_writeE      (reg_writeE),
        .mem_to_regE     (mem_to_regE),
        .write_reg_addrE (write_reg_addrE),
        .mem_to_regM     (mem_to_regM),
        .write_reg_addrM (write_reg_addrM),
        .mdu_startE      (mdu_startE),
        .mdu_useD        (mdu_useD),
        .stallF          (stallF),
        .stallD          (stallD),
        .flushD          (flushD),
        .flushE          (flushE),
        .mdu_busy        (mdu_busy)
`ifdef STALL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic expStall,
                            input logic expFlushD, input logic expBusy);
        checkOutput({tag, ".stallF"}, 32'(stallF), 32'(expStall));
        checkOutput({tag, ".stallD"}, 32'(stallD), 32'(expStall));
        checkOutput({tag, ".flushE"}, 32'(flushE), 32'(expStall));
        checkOutput({tag, ".flushD"}, 32'(flushD), 32'(expFlushD));
        checkOutput({tag, ".busy"},   32'(mdu_busy), 32'(expBusy));
    endtask

    // Presents one cycle of pipeline state just after a rising edge and settles before returning.
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic usesRs, input logic usesRt,
                                 input logic branch, input logic taken,
                                 input logic regWE, input logic memE, input logic [4:0] addrE,
                                 input logic memM, input logic [4:0] addrM,
                                 input logic mduStart, input logic mduUse);
        @(posedge clk);
        #1;
        rs_addrD        = rs;
        rt_addrD        = rt;
        uses_rsD        = usesRs;
        uses_rtD        = usesRt;
        branchD         = branch;
        branch_takenD   = taken;
        reg_writeE      = regWE;
        mem_to_regE     = memE;
        write_reg_addrE = addrE;
        mem_to_regM     = memM;
        write_reg_addrM = addrM;
        mdu_startE      = mduStart;
        mdu_useD        = mduUse;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset holds everything quiet even with a live load-use hazard and taken branch presented.
        rs_addrD = 5'd8; uses_rsD = 1'b1; mem_to_regE = 1'b1; reg_writeE = 1'b1;
        write_reg_addrE = 5'd8; branch_takenD = 1'b1; mdu_useD = 1'b1;
        #2;
        checkAll("reset", 1'b0, 1'b0, 1'b0);
        #10 rst_n = 1'b1;

        // Load-use: lw $8 in E, D reads $8 -> one stall; then load in M -> clear.
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
        checkAll("lwUse", 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
        checkAll("lwInM", 1'b0, 1'b0, 1'b0);

        // Load-use through rt.
        applyStimulus(5'd1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0);
        checkAll("lwUseRt", 1'b1, 1'b0, 1'b0);

        // Zero register and unused operand never stall.
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkAll("lwZero", 1'b0, 1'b0, 1'b0);
        applyStimulus(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
        checkAll("lwNoRead", 1'b0, 1'b0, 1'b0);

        // Non-load ALU result in E does not stall a non-branch consumer.
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        checkAll("aluFwd", 1'b0, 1'b0, 1'b0);

        // Branch: addi $5 in E, then lw $5 in M, then resolve taken.
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        checkAll("brE", 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
        checkAll("brLwM", 1'b1, 1'b0, 1'b0);
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0);
        checkAll("brTaken", 1'b0, 1'b1, 1'b0);
        // Branch with $0 destination in E does not stall.
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkAll("brZero", 1'b0, 1'b0, 1'b0);

        // MDU: mult in E at t, mfhi in D stalls t+1..t+4, proceeds at t+5.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        checkAll("mduStart", 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
            checkAll($sformatf("mduWait%0d", i), 1'b1, 1'b0, 1'b1);
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        checkAll("mduDone", 1'b0, 1'b0, 1'b0);

        // Reload at cnt=1 alongside a load-use bubble: the counter still restarts from 4.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        repeat (3) idleCycle();
        applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0);
        checkAll("reloadFlush", 1'b1, 1'b0, 1'b1);
        repeat (4) begin
            idleCycle();
            checkAll("reloadBusy", 1'b0, 1'b0, 1'b1);
        end
        idleCycle();
        checkAll("reloadIdle", 1'b0, 1'b0, 1'b0);

        // Reset at cnt=2 abandons the operation; mfhi then passes freely.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idleCycle();
        idleCycle();
        applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b1);
        checkAll("preReset", 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        checkAll("midReset", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        checkAll("postReset", 1'b0, 1'b0, 1'b0);

`ifdef STALL_PERF_EN
        // 3 load-use stall cycles and 2 taken branches from a clean reset.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) begin
            applyStimulus(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
        end
        repeat (2) begin
            applyStimulus(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        end
        idleCycle();
        idleCycle();
        checkOutput("stallCycles", stall_cycles, 32'd3);
        checkOutput("flushCount", 32'(flush_count), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
